// File: rtl/rv32_pkg.sv
// Shared RV32I types for the PC / fetch front end.
// PC-select encodings, FSM states and instruction geometry.
package rv32_pkg;

    localparam int XLEN       = 32;
    localparam int INSN_BYTES = 4;

    localparam logic [XLEN-1:0] INSN_STEP = XLEN'(INSN_BYTES);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'd0,
        PC_BR   = 2'd1,
        PC_JAL  = 2'd2,
        PC_JALR = 2'd3
    } pc_sel_e;

    function automatic logic is_redirect(input pc_sel_e sel);
        return sel != PC_SEQ;
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Next-PC selection and alignment check.
// Purely combinational; JALR has priority over JAL over taken branch.
module pc_target_calc
    import rv32_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            branch,
    input  logic            taken,
    input  logic            jal,
    input  logic            jalr,
    output logic [XLEN-1:0] target,
    output pc_sel_e         pc_sel,
    output logic            misaligned
);

    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] rel_pc;
    logic [XLEN-1:0] reg_pc;

    assign seq_pc = pc + INSN_STEP;
    assign rel_pc = pc + imm;
    assign reg_pc = (rs1 + imm) & ~{{(XLEN-1){1'b0}}, 1'b1};

    always_comb begin
        pc_sel = PC_SEQ;
        if (jalr) begin
            pc_sel = PC_JALR;
        end else if (jal) begin
            pc_sel = PC_JAL;
        end else if (branch && taken) begin
            pc_sel = PC_BR;
        end
    end

    always_comb begin
        target = seq_pc;
        case (pc_sel)
            PC_JALR: target = reg_pc;
            PC_JAL:  target = rel_pc;
            PC_BR:   target = rel_pc;
            default: target = seq_pc;
        endcase
    end

    // Sequential PC stays aligned by construction; only redirects can break it.
    assign misaligned = is_redirect(pc_sel) && target[1];

endmodule

// File: rtl/pc_next_unit.sv
// Architectural PC register, fetch request and retire counter.
// Small BOOT/RUN/HALT FSM; HALT is left only through reset.
module pc_next_unit
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             branch_i,
    input  logic             taken_i,
    input  logic             jal_i,
    input  logic             jalr_i,
    input  logic             halt_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic             stall_i,
    input  logic             fetch_ready_i,
    output logic             fetch_valid_o,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  pc_plus4_o,
    output logic             misaligned_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pc_state_e        state_q;
    logic [XLEN-1:0]  pc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             valid_q;
    logic             halted_q;
    logic             mis_q;

    logic [XLEN-1:0]  target;
    pc_sel_e          pc_sel;
    logic             target_mis;
    logic             retire;

    pc_target_calc u_calc (
        .pc         (pc_q),
        .imm        (imm_i),
        .rs1        (rs1_i),
        .branch     (branch_i),
        .taken      (taken_i),
        .jal        (jal_i),
        .jalr       (jalr_i),
        .target     (target),
        .pc_sel     (pc_sel),
        .misaligned (target_mis)
    );

    assign retire = (state_q == RUN) && fetch_ready_i && !stall_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= RUN;
                    valid_q <= 1'b1;
                end
                RUN: begin
                    if (retire && target_mis) begin
                        state_q  <= HALT;
                        valid_q  <= 1'b0;
                        halted_q <= 1'b1;
                        mis_q    <= 1'b1;
                    end else if (retire) begin
                        pc_q  <= target;
                        cnt_q <= cnt_q + CNT_ONE;
                        if (halt_i) begin
                            state_q  <= HALT;
                            valid_q  <= 1'b0;
                            halted_q <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q  <= HALT;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    assign fetch_valid_o = valid_q;
    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_q + INSN_STEP;
    assign misaligned_o  = mis_q;
    assign halted_o      = halted_q;
    assign retired_o     = cnt_q;

endmodule
